mem_arbiter: RTL and testbench

- Shares the single slow main-memory port between two requesters: the instruction-fetch refill path (I) and the data load/store path (D).
- Sits between the cache controller's two miss paths and main_memory. Serialises their transactions one at a time.
- Data has priority. A starvation guard bounds how long instruction fetch can be locked out.
- A watchdog aborts transactions that main memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_watchdog.sv | 41 ++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port main-memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_STARVE_LIMIT   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    // Width of a counter that must hold 0..max_val; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Saturating up/down counter with clear, load and enable; flags when it sits at LIMIT.
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYCLES,
    parameter int W     = cnt_width(DEF_TIMEOUT_CYCLES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         down_i,
    output logic         expired_o
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] cnt_q;

    // Saturates at both ends so the count can never wrap past the limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            if (down_i) begin
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end else begin
                if (cnt_q != LIMIT_W) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign expired_o = (cnt_q == LIMIT_W);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-refill and data load/store traffic onto one main-memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,
    output logic [1:0]        owner,
    output logic              timeout_err
);

    localparam int SW = cnt_width(STARVE_LIMIT);
    localparam int WW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e        state_q;
    owner_e            owner_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [SW-1:0]     starve_cnt_q;
    logic [SW-1:0]     starve_cnt_d;
    logic              timeout_err_q;

    logic idle, busy, grant_d, grant_i, wd_expired, done, timed_out, finish;

    assign idle = (state_q == IDLE);
    assign busy = !idle;

    // D wins unless I has already watched STARVE_LIMIT consecutive D grants.
    assign grant_d = idle && d_req && (!i_req || (starve_cnt_q != STARVE_MAX));
    assign grant_i = idle && i_req && !grant_d;

    assign done      = busy && mem_ready;
    assign timed_out = busy && !mem_ready && wd_expired;
    assign finish    = done || timed_out;

    always_comb begin
        starve_cnt_d = '0;
        if (i_req) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX : starve_cnt_q + 1'b1;
        end
    end

    arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (WW)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (grant_d || grant_i),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (busy),
        .down_i     (1'b0),
        .expired_o  (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_NONE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            starve_cnt_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q      <= BUSY_D;
                        owner_q      <= OWN_D;
                        mem_addr_q   <= d_addr;
                        mem_wdata_q  <= d_wdata;
                        mem_write_q  <= d_we;
                        mem_read_q   <= !d_we;
                        starve_cnt_q <= starve_cnt_d;
                    end else if (grant_i) begin
                        state_q      <= BUSY_I;
                        owner_q      <= OWN_I;
                        mem_addr_q   <= i_addr;
                        mem_write_q  <= 1'b0;
                        mem_read_q   <= 1'b1;
                        starve_cnt_q <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (finish) begin
                        state_q     <= IDLE;
                        owner_q     <= OWN_NONE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (timed_out) timeout_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    // A timed-out completion still pulses ready, but with zero data.
    assign i_ready = (state_q == BUSY_I) && finish;
    assign d_ready = (state_q == BUSY_D) && finish;
    assign i_rdata = ((state_q == BUSY_I) && done) ? mem_read_data : '0;
    assign d_rdata = ((state_q == BUSY_D) && done) ? mem_read_data : '0;

    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign owner          = owner_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance (STARVE_LIMIT=4, TIMEOUT_CYCLES=8) plus a STARVE_LIMIT=0 instance.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic        i_req0 = 1'b0, d_req0 = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_read_data = '0;
    logic        mem_ready = 1'b0;

    logic        i_ready, d_ready, mem_read, mem_write, timeout_err;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_write_data;
    logic [1:0]  owner;

    logic        i_ready0, d_ready0, mem_read0, mem_write0, timeout_err0;
    logic [31:0] i_rdata0, d_rdata0, mem_addr0, mem_write_data0;
    logic [1:0]  owner0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .owner(owner), .timeout_err(timeout_err)
    );

    mem_arbiter #(.STARVE_LIMIT(0), .TIMEOUT_CYCLES(255)) dut0 (
        .clk(clk), .reset(reset),
        .i_req(i_req0), .i_addr(i_addr), .i_ready(i_ready0), .i_rdata(i_rdata0),
        .d_req(d_req0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready0), .d_rdata(d_rdata0),
        .mem_addr(mem_addr0), .mem_write_data(mem_write_data0),
        .mem_read(mem_read0), .mem_write(mem_write0),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .owner(owner0), .timeout_err(timeout_err0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    logic [1:0] exp_own [6];
    int         pulses;

    initial begin
        exp_own = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

        // Reset state
        repeat (2) nxt();
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        chk("rst_readys", 32'({i_ready, d_ready}), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        reset = 1'b1;

        // I read, memory answers in the third busy cycle
        i_req = 1'b1; i_addr = 32'h40;
        nxt();
        chk("i_mem_read", 32'(mem_read), 32'h1);
        chk("i_owner", 32'(owner), 32'h1);
        chk("i_mem_addr", mem_addr, 32'h40);
        chk("i_early_ready", 32'(i_ready), 32'h0);
        nxt();
        chk("i_early_ready2", 32'(i_ready), 32'h0);
        nxt();
        mem_ready = 1'b1; mem_read_data = 32'h8C02_0000; #1;
        chk("i_ready", 32'(i_ready), 32'h1);
        chk("i_rdata", i_rdata, 32'h8C02_0000);
        chk("i_d_ready_quiet", 32'(d_ready), 32'h0);
        $display("txn I read addr=0x40 rdata=0x%08h", i_rdata);
        i_req = 1'b0;
        nxt();
        mem_ready = 1'b0;
        chk("i_after_mem_read", 32'(mem_read), 32'h0);
        chk("i_after_owner", 32'(owner), 32'h0);

        // D write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'h7; mem_read_data = '0;
        nxt();
        chk("dw_mem_write", 32'(mem_write), 32'h1);
        chk("dw_mem_read", 32'(mem_read), 32'h0);
        chk("dw_mem_addr", mem_addr, 32'h54);
        chk("dw_mem_wdata", mem_write_data, 32'h7);
        chk("dw_owner", 32'(owner), 32'h2);
        nxt();
        mem_ready = 1'b1; #1;
        chk("dw_d_ready", 32'(d_ready), 32'h1);
        chk("dw_i_ready_quiet", 32'(i_ready), 32'h0);
        chk("dw_mem_read_hold", 32'(mem_read), 32'h0);
        $display("txn D write addr=0x54 wdata=0x7");
        d_req = 1'b0; d_we = 1'b0;
        nxt();
        mem_ready = 1'b0;
        chk("dw_after_mem_write", 32'(mem_write), 32'h0);
        chk("dw_after_owner", 32'(owner), 32'h0);

        // Stray mem_ready while idle
        mem_ready = 1'b1; #1;
        chk("stray_readys", 32'({i_ready, d_ready}), 32'h0);
        nxt();
        mem_ready = 1'b0;
        chk("stray_owner", 32'(owner), 32'h0);

        // Both requesters held high: D,D,D,D,I,D; STARVE_LIMIT=0 instance grants I first
        reset = 1'b0;
        nxt();
        reset = 1'b1;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h80; d_addr = 32'h90;
        i_req0 = 1'b1; d_req0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            nxt();
            chk($sformatf("both_owner%0d", k), 32'(owner), 32'(exp_own[k]));
            chk($sformatf("both_addr%0d", k), mem_addr, (exp_own[k] == 2'b01) ? 32'h80 : 32'h90);
            if (k == 0) begin
                chk("sl0_first_owner", 32'(owner0), 32'h1);
                i_req0 = 1'b0; d_req0 = 1'b0;
            end
            if (k == 4) chk("starve_cleared", 32'(dut.starve_cnt_q), 32'h0);
            nxt();
            mem_ready = 1'b1; mem_read_data = 32'h1000 + 32'(k); #1;
            if (exp_own[k] == 2'b01) begin
                chk($sformatf("both_i_ready%0d", k), 32'({i_ready, d_ready}), 32'h2);
                chk($sformatf("both_i_rdata%0d", k), i_rdata, 32'h1000 + 32'(k));
            end else begin
                chk($sformatf("both_d_ready%0d", k), 32'({i_ready, d_ready}), 32'h1);
                chk($sformatf("both_d_rdata%0d", k), d_rdata, 32'h1000 + 32'(k));
            end
            if (k == 0) chk("sl0_i_ready", 32'(i_ready0), 32'h1);
            $display("txn arb k=%0d owner=%0d", k, owner);
            if (k == 5) begin i_req = 1'b0; d_req = 1'b0; end
            nxt();
            mem_ready = 1'b0;
            chk($sformatf("both_gap%0d", k), 32'(owner), 32'h0);
        end

        // Watchdog expiry with no mem_ready
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; mem_read_data = 32'hDEAD_BEEF;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            nxt();
            if (d_ready) pulses++;
        end
        chk("to_no_early_pulse", 32'(pulses), 32'h0);
        nxt();
        chk("to_d_ready", 32'(d_ready), 32'h1);
        chk("to_d_rdata", d_rdata, 32'h0);
        chk("to_err_not_yet", 32'(timeout_err), 32'h0);
        $display("txn D read addr=0x100 timed out");
        d_req = 1'b0;
        nxt();
        chk("to_err_set", 32'(timeout_err), 32'h1);
        chk("to_owner", 32'(owner), 32'h0);
        chk("to_mem_read", 32'(mem_read), 32'h0);

        // Normal I read afterwards; error stays sticky
        i_req = 1'b1; i_addr = 32'h44;
        nxt();
        mem_ready = 1'b1; mem_read_data = 32'h0000_A5A5; #1;
        chk("post_to_i_rdata", i_rdata, 32'h0000_A5A5);
        $display("txn I read addr=0x44 rdata=0x%08h", i_rdata);
        i_req = 1'b0;
        nxt();
        mem_ready = 1'b0;
        chk("to_err_sticky", 32'(timeout_err), 32'h1);

        // Reset during BUSY_I
        i_req = 1'b1; i_addr = 32'h48;
        nxt();
        chk("rb_owner_busy", 32'(owner), 32'h1);
        reset = 1'b0; i_req = 1'b0;
        nxt();
        chk("rb_owner", 32'(owner), 32'h0);
        chk("rb_mem_read", 32'(mem_read), 32'h0);
        chk("rb_no_ready", 32'(i_ready), 32'h0);
        chk("rb_err_clr", 32'(timeout_err), 32'h0);
        reset = 1'b1;
        nxt();
        chk("rb_idle", 32'(owner), 32'h0);
        i_req = 1'b1; i_addr = 32'h4C;
        nxt();
        chk("rb_regrant_owner", 32'(owner), 32'h1);
        chk("rb_regrant_addr", mem_addr, 32'h4C);
        mem_ready = 1'b1; mem_read_data = 32'h77; #1;
        chk("rb_regrant_rdata", i_rdata, 32'h77);
        $display("txn I read addr=0x4C after reset rdata=0x%08h", i_rdata);
        i_req = 1'b0;
        nxt();
        mem_ready = 1'b0;

        // mem_ready in the expiry cycle wins over the timeout
        d_req = 1'b1; d_addr = 32'h200;
        repeat (8) nxt();
        nxt();
        mem_ready = 1'b1; mem_read_data = 32'h1234_5678; #1;
        chk("win_d_ready", 32'(d_ready), 32'h1);
        chk("win_d_rdata", d_rdata, 32'h1234_5678);
        $display("txn D read addr=0x200 completed at limit");
        d_req = 1'b0;
        nxt();
        mem_ready = 1'b0;
        chk("win_no_err", 32'(timeout_err), 32'h0);
        chk("win_owner", 32'(owner), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
